lattice_store: RTL
==================

Name: lattice_store

Overview:
- Memory-side responder for the lattice-Boltzmann streaming/collision engines: serves the 9-lane address bus issued by the streaming master, returning read data with fixed latency and committing writes.
- Holds two ping-pong copies of the 8 moving-direction populations. Reads always hit the "current" copy and writes always hit the "next" copy, so in-place streaming never reads a value it has already overwritten.
- A low-priority host port lets the display/readout path fetch all 8 populations of one cell from the current copy.

Parameters:
- HPIXELS, 205, lattice width in cells
- VPIXELS, 154, lattice height in cells
- DATA_W, 9, bits per population value
- READ_LATENCY, 2, cycles from accepted read request to valid data; fixed 2 (registered BRAM read plus output register)
- Derived, not overridable: BRAM_DEPTH = HPIXELS*VPIXELS; BRAM_SIZE = $clog2(BRAM_DEPTH)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- req_in  input  1  engine request strobe for this cycle
- we_in  input  1  1 = write request, 0 = read request; sampled only when req_in=1
- addr_in  input  [8:0][BRAM_SIZE-1:0]  per-lane cell address; lane 0 (rest direction) is ignored, lanes 1..8 map to bank i-1
- data_in  input  [7:0][DATA_W-1:0]  write data; element i-1 goes to the lane-i address
- data_out  output  [7:0][DATA_W-1:0]  read data; element i-1 comes from the lane-i address
- valid_out  output  1  one-cycle pulse marking data_out valid
- swap_in  input  1  single-cycle pulse; exchanges the current and next copies (driven by the streaming engine's done pulse)
- bank_sel_out  output  1  index of the copy that is currently "current"
- host_re_in  input  1  host read request
- host_addr_in  input  BRAM_SIZE  host cell address
- host_ready_out  output  1  host request accepted this cycle
- host_data_out  output  [7:0][DATA_W-1:0]  all 8 populations at host_addr_in
- host_valid_out  output  1  one-cycle pulse marking host_data_out valid
- err_out  output  1  sticky flag: an out-of-range address was presented

Behaviour:
- Reset values (rst_in=0, asynchronous): bank_sel_out=0, valid_out=0, host_valid_out=0, data_out=0, host_data_out=0, err_out=0, all pipeline valid/tag registers cleared. Memory contents are not cleared.
- Storage: 2 copies x 8 banks, each bank BRAM_DEPTH x DATA_W. Copy bank_sel_out is "current"; the other copy is "next".
- Engine read (req_in=1, we_in=0):
  - Each lane i=1..8 reads current[bank i-1][addr_in[i]].
  - valid_out pulses exactly READ_LATENCY cycles later, together with data_out.
  - A new read may be accepted every cycle (fully pipelined).
- Engine write (req_in=1, we_in=1): each lane i=1..8 writes data_in[i-1] to next[bank i-1][addr_in[i]] in the same cycle. No valid_out is produced.
- Out-of-range address: any lane 1..8 with addr >= BRAM_DEPTH is dropped for that lane only.
  - A dropped read returns 0 in that element; valid_out still pulses.
  - err_out sets and holds until reset.
  - host_addr_in out of range: the request is accepted, host_data_out = all zeros, err_out sets.
- Swap:
  - swap_in=1 toggles bank_sel_out on the next edge.
  - A request accepted in the same cycle as swap_in uses the pre-swap selection.
  - Each in-flight read carries a bank tag captured at issue, so data already in the pipeline is never re-steered.
  - Back-to-back swap pulses toggle on each pulse.
- Host arbitration:
  - Engine has absolute priority. host_ready_out = host_re_in & ~req_in (combinational).
  - When accepted, host reads the current copy of all 8 banks at host_addr_in; host_valid_out pulses READ_LATENCY cycles later.
  - Host requests not accepted are not queued; the host holds host_re_in until it sees host_ready_out.
  - Host and engine read results use separate output registers and may be valid in the same cycle.
- Read/write collision in one cycle is impossible by construction, because reads go to current and writes go to next.
- Reset asserted mid-operation: in-flight reads are discarded (no valid pulses after reset deasserts) and the selection returns to copy 0.

Test Plan:
- Reset, then write lane 3 addr 100 data 9'h0A5, swap_in pulse, read with all lanes addr 100 -> 2 cycles later valid_out=1 and data_out[2]=9'h0A5; bank_sel_out=1.
- Write addr 5 = 9'h011 without swap, then read addr 5 -> data_out returns the old current-copy value, not 9'h011; after swap, read returns 9'h011.
- Reads issued on 4 consecutive cycles (addrs 0,1,2,3) with swap_in on the 2nd cycle -> 4 consecutive valid pulses; the first two come from copy 0, the last two from copy 1.
- host_re_in held high with addr 7 while req_in=1 for 3 cycles -> host_ready_out=0 for those 3 cycles; ready on the 4th; host_valid_out 2 cycles after that with the 8 populations of cell 7.
- Lane 5 addr = BRAM_DEPTH (31570) on a read -> data_out[4]=0, other lanes correct, err_out=1 and stays 1 afterwards.
- Read issued, rst_in pulled low the next cycle, then released -> no valid_out pulse; bank_sel_out=0; err_out=0.

Source files
------------

// File: rtl/lattice_store.sv
// rtl/lattice_store.sv - ping-pong population store for the lattice-Boltzmann engines
// Reads hit the current copy, writes hit the next copy; host reads share the read port at low priority.
module lattice_store #(
    parameter int  HPIXELS    = 205,
    parameter int  VPIXELS    = 154,
    parameter int  DATA_W     = 9,
    localparam int BRAM_DEPTH = HPIXELS * VPIXELS,
    localparam int BRAM_SIZE  = $clog2(BRAM_DEPTH)
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             req_in,
    input  logic                             we_in,
    input  logic [8:0][BRAM_SIZE-1:0]        addr_in,
    input  logic [7:0][DATA_W-1:0]           data_in,
    output logic [7:0][DATA_W-1:0]           data_out,
    output logic                             valid_out,
    input  logic                             swap_in,
    output logic                             bank_sel_out,
    input  logic                             host_re_in,
    input  logic [BRAM_SIZE-1:0]             host_addr_in,
    output logic                             host_ready_out,
    output logic [7:0][DATA_W-1:0]           host_data_out,
    output logic                             host_valid_out,
    output logic                             err_out
);
    localparam int READ_LATENCY = 2;

    logic                          sel_q, sel_d;
    logic                          err_q, err_d;
    logic                          eng_rd, eng_wr, host_acc, host_ok;
    logic [7:0]                    lane_ok;
    logic [7:0]                    ok_q, ok_d;
    logic [7:0][BRAM_SIZE-1:0]     rd_addr;
    logic [7:0][DATA_W-1:0]        rd_all;
    logic [7:0][DATA_W-1:0]        masked;
    logic [READ_LATENCY-1:0]       ev_q, hv_q;
    logic [7:0][DATA_W-1:0]        data_q, hdata_q;
    logic                          unused_lane0;

    // Lane 0 is the rest direction and never touches storage.
    assign unused_lane0 = ^addr_in[0];

    always_comb begin
        eng_rd   = req_in & ~we_in;
        eng_wr   = req_in & we_in;
        host_acc = host_re_in & ~req_in;
        host_ok  = int'(host_addr_in) < BRAM_DEPTH;
        for (int b = 0; b < 8; b++) begin
            lane_ok[b] = int'(addr_in[b+1]) < BRAM_DEPTH;
            ok_d[b]    = req_in ? lane_ok[b] : host_ok;
            rd_addr[b] = !ok_d[b] ? '0 : (req_in ? addr_in[b+1] : host_addr_in);
            masked[b]  = ok_q[b] ? rd_all[b] : '0;
        end
        err_d = err_q | (req_in & ~(&lane_ok)) | (host_acc & ~host_ok);
        sel_d = sel_q ^ swap_in;
    end

    for (genvar b = 0; b < 8; b++) begin : g_bank
        logic [DATA_W-1:0] copy0 [BRAM_DEPTH];
        logic [DATA_W-1:0] copy1 [BRAM_DEPTH];
        logic [DATA_W-1:0] rd_q;

        // The read is taken from the copy selected at issue, so a later swap cannot re-steer it.
        always_ff @(posedge clk_in) begin
            if (eng_wr && lane_ok[b]) begin
                if (sel_q) copy0[addr_in[b+1]] <= data_in[b];
                else       copy1[addr_in[b+1]] <= data_in[b];
            end
            if (eng_rd || host_acc) begin
                rd_q <= sel_q ? copy1[rd_addr[b]] : copy0[rd_addr[b]];
            end
        end

        assign rd_all[b] = rd_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
            ev_q    <= '0;
            hv_q    <= '0;
            ok_q    <= '0;
            data_q  <= '0;
            hdata_q <= '0;
        end else begin
            sel_q <= sel_d;
            err_q <= err_d;
            ev_q  <= {ev_q[READ_LATENCY-2:0], eng_rd};
            hv_q  <= {hv_q[READ_LATENCY-2:0], host_acc};
            if (eng_rd || host_acc) ok_q <= ok_d;
            if (ev_q[READ_LATENCY-2]) data_q  <= masked;
            if (hv_q[READ_LATENCY-2]) hdata_q <= masked;
        end
    end

    assign data_out       = data_q;
    assign valid_out      = ev_q[READ_LATENCY-1];
    assign host_data_out  = hdata_q;
    assign host_valid_out = hv_q[READ_LATENCY-1];
    assign host_ready_out = host_acc;
    assign bank_sel_out   = sel_q;
    assign err_out        = err_q;
endmodule
